// File: rtl/l2_lookup_sched_pkg.sv
// L2 lookup scheduler: shared types and constants.
// Address layout, lookup modes and FSM encoding.
package l2_lookup_sched_pkg;

  localparam int ADDR_BITS      = 32;
  localparam int WORD_OFF_BITS  = 2;
  localparam int BYTE_OFF_BITS  = 2;
  localparam int OFFSET_BITS    = WORD_OFF_BITS + BYTE_OFF_BITS;
  localparam int L2_SET_BITS    = 8;
  localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int L2_TAG_BITS    = LINE_ADDR_BITS - L2_SET_BITS;

  localparam int STARVE_MAX_DEF = 4;

  localparam logic L2_LOOKUP     = 1'b0;
  localparam logic L2_LOOKUP_FWD = 1'b1;

  typedef struct packed {
    logic [L2_TAG_BITS-1:0] tag;
    logic [L2_SET_BITS-1:0] set;
    logic [OFFSET_BITS-1:0] w_off;
  } addr_breakdown_t;

  typedef struct packed {
    logic [L2_TAG_BITS-1:0] tag;
    logic [L2_SET_BITS-1:0] set;
  } line_breakdown_l2_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LKUP = 2'd1,
    S_RESP = 2'd2
  } l2_lookup_state_t;

endpackage

// File: rtl/l2_lookup_arb.sv
// L2 lookup arbiter: forward-first grant with
// a saturating counter that protects requests.
module l2_lookup_arb
  import l2_lookup_sched_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  localparam int CW = $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_valid,
  input  logic req_conflict,
  input  logic fwd_valid,
  input  logic fwd_conflict,
  output logic grant_req,
  output logic grant_fwd
);

  logic [CW-1:0] starve_cnt;
  logic          req_elig;
  logic          fwd_elig;
  logic          force_req;

  // Eligibility and grant; a starved request overrides a forward.
  always_comb begin
    req_elig  = en && req_valid && !req_conflict;
    fwd_elig  = en && fwd_valid && !fwd_conflict;
    force_req = req_elig && (starve_cnt == CW'(STARVE_MAX));
    grant_fwd = fwd_elig && !force_req;
    grant_req = req_elig && !grant_fwd;
  end

  // Count forward grants that passed over a waiting request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_req) begin
      starve_cnt <= '0;
    end else if (grant_fwd && req_elig &&
                 starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/l2_lookup_sched.sv
// L2 lookup scheduler: picks a request or forward,
// reads the set, runs lookup, holds the result.
module l2_lookup_sched
  import l2_lookup_sched_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [ADDR_BITS-1:0]      req_addr,
  input  logic                      req_conflict,
  output logic                      req_ready,
  input  logic                      fwd_valid,
  input  logic [LINE_ADDR_BITS-1:0] fwd_addr,
  input  logic                      fwd_conflict,
  output logic                      fwd_ready,
  output logic                      rd_en,
  output logic [L2_SET_BITS-1:0]    rd_set,
  output logic                      lookup_en,
  output logic                      lookup_mode,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_is_fwd,
  output logic [ADDR_BITS-1:0]      res_addr,
  output logic                      busy
);

  l2_lookup_state_t       state;
  l2_lookup_state_t       state_nx;
  addr_breakdown_t        req_bd;
  line_breakdown_l2_t     fwd_bd;
  logic                   idle;
  logic                   grant_req;
  logic                   grant_fwd;
  logic [L2_TAG_BITS-1:0] lat_tag;
  logic [L2_SET_BITS-1:0] lat_set;
  logic [OFFSET_BITS-1:0] lat_off;
  logic                   lat_fwd;

  assign req_bd = addr_breakdown_t'(req_addr);
  assign fwd_bd = line_breakdown_l2_t'(fwd_addr);
  assign idle   = rst && (state == S_IDLE);

  l2_lookup_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .en          (idle),
    .req_valid   (req_valid),
    .req_conflict(req_conflict),
    .fwd_valid   (fwd_valid),
    .fwd_conflict(fwd_conflict),
    .grant_req   (grant_req),
    .grant_fwd   (grant_fwd)
  );

  // Next state and per-state outputs.
  always_comb begin
    state_nx    = state;
    req_ready   = grant_req;
    fwd_ready   = grant_fwd;
    rd_en       = grant_req || grant_fwd;
    rd_set      = '0;
    lookup_en   = 1'b0;
    lookup_mode = L2_LOOKUP;
    res_valid   = 1'b0;
    busy        = (state != S_IDLE);
    unique case (1'b1)
      grant_fwd: rd_set = fwd_bd.set;
      grant_req: rd_set = req_bd.set;
      default:   rd_set = '0;
    endcase
    unique case (state)
      S_IDLE: begin
        if (rd_en) state_nx = S_LKUP;
      end
      S_LKUP: begin
        lookup_en   = 1'b1;
        lookup_mode = lat_fwd;
        state_nx    = S_RESP;
      end
      S_RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register; reset abandons any operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Capture the granted operation; forwards get zero offset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_tag <= '0;
      lat_set <= '0;
      lat_off <= '0;
      lat_fwd <= 1'b0;
    end else if (grant_fwd) begin
      lat_tag <= fwd_bd.tag;
      lat_set <= fwd_bd.set;
      lat_off <= '0;
      lat_fwd <= 1'b1;
    end else if (grant_req) begin
      lat_tag <= req_bd.tag;
      lat_set <= req_bd.set;
      lat_off <= req_bd.w_off;
      lat_fwd <= 1'b0;
    end
  end

  assign res_is_fwd = lat_fwd;
  assign res_addr   = {lat_tag, lat_set, lat_off};

endmodule

// File: tb/tb_l2_lookup_sched.sv
// Directed bench for l2_lookup_sched.
// Hand-computed expectations, default STARVE_MAX.
module tb_l2_lookup_sched;
  import l2_lookup_sched_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      req_valid;
  logic [ADDR_BITS-1:0]      req_addr;
  logic                      req_conflict;
  logic                      req_ready;
  logic                      fwd_valid;
  logic [LINE_ADDR_BITS-1:0] fwd_addr;
  logic                      fwd_conflict;
  logic                      fwd_ready;
  logic                      rd_en;
  logic [L2_SET_BITS-1:0]    rd_set;
  logic                      lookup_en;
  logic                      lookup_mode;
  logic                      res_valid;
  logic                      res_ready;
  logic                      res_is_fwd;
  logic [ADDR_BITS-1:0]      res_addr;
  logic                      busy;

  int n_assert = 0;
  int n_fail   = 0;
  int mcnt;
  logic exp_f;

  localparam logic [31:0] RA = 32'h0001_2344;
  localparam logic [27:0] FA = 28'h0AB_CDE7;
  localparam logic [31:0] FR = 32'h0ABC_DE70;

  l2_lookup_sched dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_conflict(req_conflict),
    .req_ready   (req_ready),
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_conflict(fwd_conflict),
    .fwd_ready   (fwd_ready),
    .rd_en       (rd_en),
    .rd_set      (rd_set),
    .lookup_en   (lookup_en),
    .lookup_mode (lookup_mode),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_is_fwd  (res_is_fwd),
    .res_addr    (res_addr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Grant in IDLE now, then LKUP, then RESP (res_ready=1).
  task automatic op(input logic ef,
                    input logic [31:0] ea,
                    input string tag);
    chk({tag, ".fwd_ready"}, fwd_ready, ef);
    chk({tag, ".req_ready"}, req_ready, !ef);
    chk({tag, ".rd_en"}, rd_en, 1);
    chk({tag, ".rd_set"}, rd_set, ea[11:4]);
    @(negedge clk); #1;
    chk({tag, ".lookup_en"}, lookup_en, 1);
    chk({tag, ".lookup_mode"}, lookup_mode, ef);
    chk({tag, ".lkup_rd_en"}, rd_en, 0);
    @(negedge clk); #1;
    chk({tag, ".res_valid"}, res_valid, 1);
    chk({tag, ".res_is_fwd"}, res_is_fwd, ef);
    chk({tag, ".res_addr"}, res_addr, ea);
    chk({tag, ".resp_lookup_en"}, lookup_en, 0);
  endtask

  initial begin
    rst          = 1'b0;
    req_valid    = 1'b1;
    req_addr     = RA;
    req_conflict = 1'b0;
    fwd_valid    = 1'b1;
    fwd_addr     = FA;
    fwd_conflict = 1'b0;
    res_ready    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.req_ready", req_ready, 0);
    chk("rst.fwd_ready", fwd_ready, 0);
    chk("rst.rd_en", rd_en, 0);
    chk("rst.rd_set", rd_set, 0);
    chk("rst.lookup_en", lookup_en, 0);
    chk("rst.lookup_mode", lookup_mode, L2_LOOKUP);
    chk("rst.res_valid", res_valid, 0);
    chk("rst.res_is_fwd", res_is_fwd, 0);
    chk("rst.res_addr", res_addr, 0);
    chk("rst.busy", busy, 0);

    // Lone request, then 5 cycles of backpressure.
    fwd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("lone.req_ready", req_ready, 1);
    chk("lone.fwd_ready", fwd_ready, 0);
    chk("lone.rd_en", rd_en, 1);
    chk("lone.rd_set", rd_set, 8'h34);
    chk("lone.busy_t", busy, 0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("lone.lookup_en", lookup_en, 1);
    chk("lone.lookup_mode", lookup_mode, L2_LOOKUP);
    chk("lone.lkup_rd_en", rd_en, 0);
    chk("lone.busy", busy, 1);
    chk("lone.lkup_res_valid", res_valid, 0);
    @(negedge clk); #1;
    chk("lone.res_valid", res_valid, 1);
    chk("lone.res_addr", res_addr, RA);
    chk("lone.res_is_fwd", res_is_fwd, 0);
    chk("lone.resp_lookup_en", lookup_en, 0);

    req_valid = 1'b1;
    fwd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("bp.res_valid", res_valid, 1);
      chk("bp.res_addr", res_addr, RA);
      chk("bp.res_is_fwd", res_is_fwd, 0);
      chk("bp.req_ready", req_ready, 0);
      chk("bp.fwd_ready", fwd_ready, 0);
      chk("bp.rd_en", rd_en, 0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    chk("bp.rel_res_valid", res_valid, 1);
    chk("bp.rel_fwd_ready", fwd_ready, 0);
    chk("bp.rel_rd_en", rd_en, 0);
    @(negedge clk); #1;
    chk("bp.next_fwd_ready", fwd_ready, 1);
    chk("bp.next_req_ready", req_ready, 0);
    chk("bp.next_rd_set", rd_set, 8'he7);

    // Reset asserted while in LKUP.
    @(negedge clk); #1;
    chk("rl.lookup_en_pre", lookup_en, 1);
    chk("rl.lookup_mode_pre", lookup_mode, L2_LOOKUP_FWD);
    rst = 1'b0;
    #1;
    chk("rl.lookup_en", lookup_en, 0);
    chk("rl.lookup_mode", lookup_mode, L2_LOOKUP);
    chk("rl.busy", busy, 0);
    chk("rl.res_valid", res_valid, 0);
    chk("rl.res_addr", res_addr, 0);
    chk("rl.res_is_fwd", res_is_fwd, 0);
    chk("rl.fwd_ready", fwd_ready, 0);
    chk("rl.rd_en", rd_en, 0);
    chk("rl.starve_cnt", dut.u_arb.starve_cnt, 0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("rl.hold_res_valid", res_valid, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rl.rel_res_valid", res_valid, 0);

    // Both eligible: F,F,F,F,R repeating.
    mcnt = 0;
    for (int i = 0; i < 10; i++) begin
      exp_f = (mcnt != 4);
      op(exp_f, exp_f ? FR : RA, "starve");
      if (exp_f) mcnt = mcnt + 1;
      else       mcnt = 0;
      @(negedge clk); #1;
    end

    // Forward conflicting: request goes, no counting.
    fwd_conflict = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      op(1'b0, RA, "fconf");
      chk("fconf.fwd_ready", fwd_ready, 0);
      @(negedge clk); #1;
      chk("fconf.starve_cnt", dut.u_arb.starve_cnt, 0);
    end

    // Request conflicting: forward goes, no counting.
    fwd_conflict = 1'b0;
    req_conflict = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      op(1'b1, FR, "rconf");
      @(negedge clk); #1;
      chk("rconf.starve_cnt", dut.u_arb.starve_cnt, 0);
    end

    // Both conflicting: nothing granted.
    fwd_conflict = 1'b1;
    #1;
    repeat (2) begin
      chk("both.req_ready", req_ready, 0);
      chk("both.fwd_ready", fwd_ready, 0);
      chk("both.rd_en", rd_en, 0);
      chk("both.busy", busy, 0);
      @(negedge clk); #1;
    end

    // Clear conflicts: forward wins and counts once.
    fwd_conflict = 1'b0;
    req_conflict = 1'b0;
    #1;
    op(1'b1, FR, "clr");
    chk("clr.starve_cnt", dut.u_arb.starve_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
